// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns an intensity value into exactly `value` evenly spread
// spikes over a window of 2**WIN_W steps using a first-order accumulator.
module spike_rate_encoder #(
  parameter int WIN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIN_W:0]   in_value,
  output logic             in_ready,
  input  logic             hold,
  output logic             spike_out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIN_W:0]   VAL_MAX  = (WIN_W+1)'(1) << WIN_W;
  localparam logic [WIN_W+1:0] WIN_LEN  = (WIN_W+2)'(1) << WIN_W;
  localparam logic [WIN_W-1:0] CNT_LAST = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [WIN_W-1:0]   acc_reg, acc_next;
  logic [WIN_W-1:0]   cnt_reg, cnt_next;
  logic [WIN_W:0]     val_reg, val_next;
  logic               spike_reg, spike_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic               step;
  logic               final_step;
  logic               accept;
  logic [WIN_W+1:0]   sum;

  assign step       = (state_reg == RUN) && !hold;
  assign final_step = step && (cnt_reg == CNT_LAST);
  assign in_ready   = (state_reg == IDLE) || final_step;
  assign accept     = in_valid && in_ready;
  assign sum        = {2'b00, acc_reg} + {1'b0, val_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      val_reg   <= '0;
      spike_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      val_reg   <= val_next;
      spike_reg <= spike_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    val_next   = val_reg;
    spike_next = 1'b0;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    if (step) begin
      if (sum >= WIN_LEN) begin
        spike_next = 1'b1;
        acc_next   = WIN_W'(sum - WIN_LEN);
      end else begin
        acc_next   = WIN_W'(sum);
      end
      cnt_next = cnt_reg + 1'b1;
      if (final_step) begin
        done_next  = 1'b1;
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    end

    // A load on the final step overrides the return to IDLE but keeps that
    // step's spike/done, so consecutive windows abut with no gap.
    if (accept) begin
      val_next   = (in_value > VAL_MAX) ? VAL_MAX : in_value;
      acc_next   = '0;
      cnt_next   = '0;
      state_next = RUN;
      busy_next  = 1'b1;
    end
  end

  assign spike_out = spike_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed plus randomized checks of spike_rate_encoder against a model that
// derives each step's spike from floor(k*val/N) differences.
module tb_spike_rate_encoder;

  localparam int WIN_W = 4;
  localparam int N     = 1 << WIN_W;
  localparam int NW    = 3;   // neuron synaptic weight
  localparam int NTH   = 7;   // neuron firing threshold

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic [WIN_W:0] in_value;
  logic           in_ready;
  logic           hold;
  logic           spike_out;
  logic           busy;
  logic           done;

  spike_rate_encoder #(.WIN_W(WIN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_value (in_value),
    .in_ready (in_ready),
    .hold     (hold),
    .spike_out(spike_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // reference model state: window running, steps taken, window value
  bit m_run = 0;
  int m_k   = 0;
  int m_v   = 0;
  int dut_win_spikes = 0;
  // integrate-and-fire neurons fed by the DUT stream and the reference stream
  int n_dut_pot = 0, n_dut_fires = 0;
  int n_ref_pot = 0, n_ref_fires = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic neuron(inout int pot, inout int fires, input int spk);
    pot += spk * NW;
    if (pot >= NTH) begin
      pot -= NTH;
      fires++;
    end
  endtask

  // One clock: drive at negedge, check in_ready, step the model, check outputs.
  task automatic cycle(input bit vld, input int value, input bit hld);
    bit exp_ready;
    int exp_spike, exp_done, ended_v;
    in_valid = vld;
    in_value = value[WIN_W:0];
    hold     = hld;
    #1;
    exp_ready = !m_run || (m_k == N-1 && !hld);
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    exp_spike = 0;
    exp_done  = 0;
    ended_v   = -1;
    if (m_run && !hld) begin
      m_k++;
      exp_spike = (m_k * m_v) / N - ((m_k - 1) * m_v) / N;
      if (m_k == N) begin
        exp_done = 1;
        ended_v  = m_v;
        m_run    = 0;
      end
    end
    if (vld && exp_ready) begin
      m_v   = (value[WIN_W:0] > N) ? N : int'(value[WIN_W:0]);
      m_k   = 0;
      m_run = 1;
    end
    @(posedge clk);
    @(negedge clk);
    check("spike_out", {31'b0, spike_out}, exp_spike);
    check("done", {31'b0, done}, exp_done);
    check("busy", {31'b0, busy}, {31'b0, m_run});
    $display("cyc vld=%0d val=%0d hold=%0d -> rdy=%0d spike=%0d done=%0d busy=%0d",
             vld, value[WIN_W:0], hld, exp_ready, spike_out, done, busy);
    dut_win_spikes += int'(spike_out);
    neuron(n_dut_pot, n_dut_fires, int'(spike_out));
    neuron(n_ref_pot, n_ref_fires, exp_spike);
    if (exp_done != 0) begin
      check("win_total", dut_win_spikes, ended_v);
      dut_win_spikes = 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, int'($urandom_range(0, 31)), 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    hold     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_spike", {31'b0, spike_out}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    reset = 1'b0;

    // value 3: spikes after steps 6, 11, 16
    cycle(1, 3, 0);
    idle_cycles(N + 1);

    // 8 then 5 back-to-back, valid held high through window 1
    cycle(1, 8, 0);
    for (int i = 0; i < N; i++) cycle(1, 5, 0);
    idle_cycles(N + 1);

    // boundaries: 0, 16, and 20 clamped to 16
    cycle(1, 0, 0);  idle_cycles(N);
    cycle(1, 16, 0); idle_cycles(N);
    cycle(1, 20, 0); idle_cycles(N + 1);

    // value 3 with hold for 5 cycles after 3 steps
    cycle(1, 3, 0);
    idle_cycles(3);
    for (int i = 0; i < 5; i++) cycle(1, 7, 1);
    idle_cycles(N - 3 + 1);

    // asynchronous reset at step 7 of a full-rate window
    cycle(1, 16, 0);
    idle_cycles(7);
    reset = 1'b1;
    #1;
    check("arst_spike", {31'b0, spike_out}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    m_run = 0; m_k = 0; m_v = 0;
    dut_win_spikes = 0;
    idle_cycles(2);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 40; i++) cycle(0, 0, 0);

    // value 12 drives a neuron; fire counts must agree
    n_dut_pot = 0; n_dut_fires = 0; n_ref_pot = 0; n_ref_fires = 0;
    cycle(1, 12, 0);
    idle_cycles(N + 1);
    check("neuron_fires", n_dut_fires, n_ref_fires);
    check("neuron_fires_abs", n_dut_fires, (12 * NW) / NTH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
